ramb16_s2_s18_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives an X_RAMB16_S2_S18-style dual-port RAM.
- A serial 2-bit symbol stream is written through RAM port A; packed 16-bit words are read through RAM port B.
- Sits between a 2-bit symbol source (deserializer or line decoder) and a 16-bit word consumer.
- Owns the pointers, full/empty flags and read-valid timing. The RAM is instantiated beside it, not inside it.

---
 rtl/ramb16_s2_s18_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_ramb16_s2_s18_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ramb16_s2_s18_fifo_ctrl.sv
// FIFO controller for an X_RAMB16_S2_S18-style RAM: 2-bit symbols written on port A, packed 16-bit words read on port B.
// Define RAMB16_FIFO_ERR_FLAGS_EN to add sticky OVF/UDF error outputs.
module ramb16_s2_s18_fifo_ctrl #(
    parameter int AFULL_SYMS = 8184
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [1:0]  DIN,
    output logic        FULL,
    output logic        ALMOST_FULL,
    input  logic        RD_EN,
    output logic [15:0] DOUT,
    output logic        DOUT_VALID,
    output logic        EMPTY,
    output logic [12:0] RAM_ADDRA,
    output logic [1:0]  RAM_DIA,
    output logic        RAM_ENA,
    output logic        RAM_WEA,
    output logic [9:0]  RAM_ADDRB,
    output logic        RAM_ENB,
    input  logic [15:0] RAM_DOB
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
    ,
    output logic        OVF,
    output logic        UDF
`endif
);

    localparam logic [13:0] AFULL_OCC = 14'(AFULL_SYMS);

    logic [13:0] wptr_q, wptr_d;
    logic [10:0] rptr_q, rptr_d;
    logic        dout_valid_q, dout_valid_d;
    logic [13:0] occ;
    logic        wr_acc, rd_acc;

    // Occupancy in symbols; the read pointer counts whole 8-symbol words.
    assign occ         = wptr_q - {rptr_q, 3'b000};
    assign FULL        = (occ == 14'd8192);
    assign EMPTY       = (occ < 14'd8);
    assign ALMOST_FULL = (occ >= AFULL_OCC);

    assign wr_acc = WR_EN & ~FULL & ~RST;
    assign rd_acc = RD_EN & ~EMPTY & ~RST;

    assign RAM_ENA    = wr_acc;
    assign RAM_WEA    = wr_acc;
    assign RAM_ADDRA  = wptr_q[12:0];
    assign RAM_DIA    = DIN;
    assign RAM_ENB    = rd_acc;
    assign RAM_ADDRB  = rptr_q[9:0];
    assign DOUT       = RAM_DOB;
    assign DOUT_VALID = dout_valid_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        dout_valid_d = rd_acc;
        if (wr_acc) wptr_d = wptr_q + 14'd1;
        if (rd_acc) rptr_d = rptr_q + 11'd1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef RAMB16_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky: a dropped request latches its flag until the next reset.
    always_comb begin
        ovf_d = ovf_q | (WR_EN & FULL);
        udf_d = udf_q | (RD_EN & EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_ramb16_s2_s18_fifo_ctrl.sv
// Self-checking bench for ramb16_s2_s18_fifo_ctrl: constant vector table, corner sequences,
// and random traffic against a symbol-queue reference model with a behavioural RAM beside the DUT.
module tb_ramb16_s2_s18_fifo_ctrl;

    localparam int AFULL = 8184;

    logic        CLK = 1'b0;
    logic        RST, WR_EN, RD_EN;
    logic [1:0]  DIN;
    logic        FULL, ALMOST_FULL, DOUT_VALID, EMPTY;
    logic [15:0] DOUT;
    logic [12:0] RAM_ADDRA;
    logic [1:0]  RAM_DIA;
    logic        RAM_ENA, RAM_WEA, RAM_ENB;
    logic [9:0]  RAM_ADDRB;
    logic [15:0] RAM_DOB;
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
    logic        OVF, UDF;
`endif

    ramb16_s2_s18_fifo_ctrl #(.AFULL_SYMS(AFULL)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .RD_EN(RD_EN), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .EMPTY(EMPTY), .RAM_ADDRA(RAM_ADDRA),
        .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
        .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_DOB(RAM_DOB)
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
        , .OVF(OVF), .UDF(UDF)
`endif
    );

    always #5 CLK = ~CLK;

    // Behavioural dual-port RAM: 8192 x 2 on port A, 1024 x 16 on port B.
    logic [1:0] ram [0:8191];
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) ram[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB)
            for (int k = 0; k < 8; k++) RAM_DOB[2*k +: 2] <= ram[{RAM_ADDRB, 3'(k)}];
    end

    int n_vec, n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a plain queue of symbols.
    logic [1:0]  sym_q[$];
    int unsigned wr_total, rd_total;
    logic        exp_valid, exp_ovf, exp_udf;
    logic [15:0] exp_word;
    int          valid_seen;
    logic        pre_enb_s, pre_wea_s;

    task automatic model_reset();
        sym_q.delete();
        wr_total  = 0;
        rd_total  = 0;
        exp_valid = 1'b0;
        exp_word  = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // One clock: drive inputs, check pre-edge outputs against the model, advance model, clock.
    task automatic step(input logic rst, input logic wr, input logic [1:0] din, input logic rd);
        logic full_e, empty_e, af_e, wacc, racc;
        RST = rst; WR_EN = wr; DIN = din; RD_EN = rd;
        #1;
        full_e  = (sym_q.size() == 8192);
        empty_e = (sym_q.size() < 8);
        af_e    = (sym_q.size() >= AFULL);
        wacc    = wr && !rst && !full_e;
        racc    = rd && !rst && !empty_e;
        check("FULL", 32'(FULL), 32'(full_e));
        check("EMPTY", 32'(EMPTY), 32'(empty_e));
        check("ALMOST_FULL", 32'(ALMOST_FULL), 32'(af_e));
        check("RAM_ENA", 32'(RAM_ENA), 32'(wacc));
        check("RAM_WEA", 32'(RAM_WEA), 32'(wacc));
        check("RAM_ENB", 32'(RAM_ENB), 32'(racc));
        if (wacc) begin
            check("RAM_ADDRA", 32'(RAM_ADDRA), wr_total % 8192);
            check("RAM_DIA", 32'(RAM_DIA), 32'(din));
        end
        if (racc) check("RAM_ADDRB", 32'(RAM_ADDRB), rd_total % 1024);
        check("DOUT_VALID", 32'(DOUT_VALID), 32'(exp_valid));
        if (exp_valid) check("DOUT", 32'(DOUT), 32'(exp_word));
        if (DOUT_VALID === 1'b1) valid_seen++;
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
        check("OVF", 32'(OVF), 32'(exp_ovf));
        check("UDF", 32'(UDF), 32'(exp_udf));
`endif
        pre_enb_s = RAM_ENB;
        pre_wea_s = RAM_WEA;
        if (rst) begin
            model_reset();
        end else begin
            if (wr && full_e)  exp_ovf = 1'b1;
            if (rd && empty_e) exp_udf = 1'b1;
            if (racc) begin
                for (int k = 0; k < 8; k++) exp_word[2*k +: 2] = sym_q.pop_front();
                rd_total++;
            end
            exp_valid = racc;
            if (wacc) begin
                sym_q.push_back(din);
                wr_total++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        rst, wr, rd;
        logic [1:0]  din;
        logic        pre_enb;
        logic        post_empty, post_valid;
        logic [15:0] post_dout;
    } vec_t;

    function automatic vec_t mk(logic rst, logic wr, logic [1:0] din, logic rd,
                                logic pre_enb, logic post_empty, logic post_valid,
                                logic [15:0] post_dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.rd = rd; v.pre_enb = pre_enb;
        v.post_empty = post_empty; v.post_valid = post_valid; v.post_dout = post_dout;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [0:20];
        int   sent;
        logic w, r, rs;

        n_vec = 0; n_err = 0; valid_seen = 0;
        RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DIN = 2'd0;
        model_reset();
        @(posedge CLK);
        #1;

        // Constant vectors: 0,1,2,3,0,1,2,3 -> E4E4; then 7x'3' with RD_EN held, 8th completes -> FFFF.
        tbl[0] = mk(1, 0, 2'd0, 0, 0, 1, 0, 16'h0000);
        for (int i = 0; i < 8; i++)
            tbl[1+i] = mk(0, 1, 2'(i), 0, 0, (i < 7), 0, 16'h0000);
        tbl[9]  = mk(0, 0, 2'd0, 1, 1, 1, 1, 16'hE4E4);
        tbl[10] = mk(0, 0, 2'd0, 0, 0, 1, 0, 16'h0000);
        for (int i = 0; i < 7; i++)
            tbl[11+i] = mk(0, 1, 2'd3, 1, 0, 1, 0, 16'h0000);
        tbl[18] = mk(0, 1, 2'd3, 1, 0, 0, 0, 16'h0000);
        tbl[19] = mk(0, 0, 2'd0, 1, 1, 1, 1, 16'hFFFF);
        tbl[20] = mk(0, 0, 2'd0, 0, 0, 1, 0, 16'h0000);
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].din, tbl[i].rd);
            check($sformatf("tbl%0d_enb", i), 32'(pre_enb_s), 32'(tbl[i].pre_enb));
            check($sformatf("tbl%0d_empty", i), 32'(EMPTY), 32'(tbl[i].post_empty));
            check($sformatf("tbl%0d_valid", i), 32'(DOUT_VALID), 32'(tbl[i].post_valid));
            if (tbl[i].post_valid)
                check($sformatf("tbl%0d_dout", i), 32'(DOUT), 32'(tbl[i].post_dout));
        end

        // Fill to FULL, overflow attempt, then simultaneous write+read at FULL.
        step(1, 0, 2'd0, 0);
        for (int i = 0; i < 8192; i++) begin
            step(0, 1, 2'(i), 0);
            if (i == 8182) check("af_below", 32'(ALMOST_FULL), 32'd0);
            if (i == 8183) check("af_at", 32'(ALMOST_FULL), 32'd1);
            if (i == 8190) check("full_below", 32'(FULL), 32'd0);
        end
        check("full_set", 32'(FULL), 32'd1);
        step(0, 1, 2'd1, 0);
        check("ovf_wea", 32'(pre_wea_s), 32'd0);
        check("ovf_full_kept", 32'(FULL), 32'd1);
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
        check("ovf_sticky", 32'(OVF), 32'd1);
`endif
        step(0, 1, 2'd2, 1);
        check("full_rw_enb", 32'(pre_enb_s), 32'd1);
        check("full_rw_wea", 32'(pre_wea_s), 32'd0);
        check("full_rw_full", 32'(FULL), 32'd0);
        check("full_rw_af", 32'(ALMOST_FULL), 32'd1);
        step(0, 1, 2'd3, 0);
        step(0, 0, 2'd0, 1);

        // Streaming over three full wraps of the symbol space.
        step(1, 0, 2'd0, 0);
        valid_seen = 0;
        sent = 0;
        for (int c = 0; c < 30000; c++) begin
            if (sent >= 24576 && sym_q.size() < 8 && !exp_valid) break;
            w = (sent < 24576);
            r = (sym_q.size() >= 8);
            step(0, w, 2'(sent / 3), r);
            if (w) sent++;
        end
        check("stream_sent", 32'(sent), 32'd24576);
        check("stream_words", 32'(valid_seen), 32'd3072);

        // Random traffic with occasional reset.
        step(1, 0, 2'd0, 0);
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 45);
            step(rs, w, 2'($urandom_range(0, 3)), r);
        end

        // Read in flight, then reset on the next edge.
        step(1, 0, 2'd0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 2'(i + 1), 0);
        step(0, 0, 2'd0, 1);
        step(1, 0, 2'd0, 1);
        check("rst_valid", 32'(DOUT_VALID), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
`ifdef RAMB16_FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_udf", 32'(UDF), 32'd0);
`endif
        step(0, 0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
